// File: rtl/country_road_sensor.sv
// Country-road vehicle sensor: synchronises and debounces the arrival and exit loops, counts the
// queue, and raises the X car-waiting request, with a green time limit and a forced hold-off.
module country_road_sensor #(
  parameter int unsigned DEBOUNCE  = 4,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned MAX_GREEN = 32,
  parameter int unsigned HOLDOFF   = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             loop_raw,
  input  logic             exit_raw,
  input  logic [1:0]       cntry,
  output logic             X,
  output logic [CNT_W-1:0] car_count,
  output logic             overflow,
  output logic             timeout
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE + 1);
  localparam int unsigned GT_W = $clog2(MAX_GREEN + 1);
  localparam int unsigned HO_W = $clog2(HOLDOFF + 1);

  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE - 1);
  localparam logic [GT_W-1:0]  GT_LAST = GT_W'(MAX_GREEN - 1);
  localparam logic [HO_W-1:0]  HO_LAST = HO_W'(HOLDOFF - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [1:0]       GREEN   = 2'd2;

  typedef enum logic [1:0] {
    IDLE_ST    = 2'b00,
    REQ_ST     = 2'b01,
    HOLDOFF_ST = 2'b10
  } state_t;

  // Bit 0 is the arrival loop, bit 1 the stop-line exit loop.
  logic [1:0]            w_raw;
  logic [1:0]            r_sync1;
  logic [1:0]            r_sync2;
  logic [1:0]            r_db;
  logic [1:0]            r_db_d;
  logic [1:0][DB_W-1:0]  r_db_cnt;
  logic [1:0]            w_db_nxt;
  logic [1:0][DB_W-1:0]  w_db_cnt_nxt;

  logic                  w_arr_ev;
  logic                  w_dep_ev;
  logic [CNT_W-1:0]      r_car_count;
  logic [CNT_W-1:0]      w_car_count_nxt;
  logic                  r_overflow;
  logic                  w_ovf_set;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [GT_W-1:0]       r_green;
  logic [GT_W-1:0]       w_green_nxt;
  logic [HO_W-1:0]       r_hold;
  logic [HO_W-1:0]       w_hold_nxt;
  logic                  w_is_green;

  assign w_raw = {exit_raw, loop_raw};

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // The stability counter only runs while the synchronised value disagrees with db.
  always_comb begin
    w_db_nxt     = r_db;
    w_db_cnt_nxt = '0;
    for (int i = 0; i < 2; i++) begin
      if (r_sync2[i] != r_db[i]) begin
        if (r_db_cnt[i] == DB_LAST) begin
          w_db_nxt[i] = r_sync2[i];
        end else begin
          w_db_cnt_nxt[i] = r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_db     <= '0;
      r_db_d   <= '0;
      r_db_cnt <= '0;
    end else begin
      r_db     <= w_db_nxt;
      r_db_d   <= r_db;
      r_db_cnt <= w_db_cnt_nxt;
    end
  end

  assign w_arr_ev = r_db[0] & ~r_db_d[0];
  assign w_dep_ev = r_db[1] & ~r_db_d[1];

  always_comb begin
    w_car_count_nxt = r_car_count;
    w_ovf_set       = 1'b0;
    case ({w_arr_ev, w_dep_ev})
      2'b10: begin
        if (r_car_count == CNT_MAX) begin
          w_ovf_set = 1'b1;
        end else begin
          w_car_count_nxt = r_car_count + 1'b1;
        end
      end
      2'b01: begin
        if (r_car_count != '0) begin
          w_car_count_nxt = r_car_count - 1'b1;
        end
      end
      default: w_car_count_nxt = r_car_count;
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_car_count <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_car_count <= w_car_count_nxt;
      r_overflow  <= r_overflow | w_ovf_set;
    end
  end

  assign w_is_green = (cntry == GREEN);

  // An empty queue takes priority over the green time limit.
  always_comb begin
    w_state_nxt = r_state;
    w_green_nxt = r_green;
    w_hold_nxt  = r_hold;
    case (r_state)
      IDLE_ST: begin
        w_green_nxt = '0;
        w_hold_nxt  = '0;
        if (r_car_count != '0) begin
          w_state_nxt = REQ_ST;
        end
      end
      REQ_ST: begin
        if (w_is_green) begin
          w_green_nxt = r_green + 1'b1;
        end
        if (r_car_count == '0) begin
          w_state_nxt = IDLE_ST;
          w_green_nxt = '0;
        end else if (w_is_green && (r_green == GT_LAST)) begin
          w_state_nxt = HOLDOFF_ST;
          w_green_nxt = '0;
          w_hold_nxt  = '0;
        end
      end
      HOLDOFF_ST: begin
        w_hold_nxt = r_hold + 1'b1;
        if (r_hold == HO_LAST) begin
          w_hold_nxt  = '0;
          w_state_nxt = (r_car_count != '0) ? REQ_ST : IDLE_ST;
        end
      end
      default: begin
        w_state_nxt = IDLE_ST;
        w_green_nxt = '0;
        w_hold_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_state <= IDLE_ST;
      r_green <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_green <= w_green_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  assign X         = (r_state == REQ_ST);
  assign timeout   = (r_state == HOLDOFF_ST);
  assign car_count = r_car_count;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_country_road_sensor.sv
// Directed bench for country_road_sensor: latency, glitch rejection, saturation, green timeout,
// simultaneous events and asynchronous clear, all with the default parameters.
module tb_country_road_sensor;

  logic       clk;
  logic       clear;
  logic       loop_raw;
  logic       exit_raw;
  logic [1:0] cntry;
  logic       X;
  logic [3:0] car_count;
  logic       overflow;
  logic       timeout;

  int n_checks;
  int n_errors;

  country_road_sensor #(
    .DEBOUNCE  (4),
    .CNT_W     (4),
    .MAX_GREEN (32),
    .HOLDOFF   (16)
  ) dut (
    .clk       (clk),
    .clear     (clear),
    .loop_raw  (loop_raw),
    .exit_raw  (exit_raw),
    .cntry     (cntry),
    .X         (X),
    .car_count (car_count),
    .overflow  (overflow),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_loop();
    loop_raw = 1'b1;
    tick(10);
    loop_raw = 1'b0;
    tick(12);
  endtask

  task automatic pulse_exit();
    exit_raw = 1'b1;
    tick(10);
    exit_raw = 1'b0;
    tick(12);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear    = 1'b0;
    loop_raw = 1'b0;
    exit_raw = 1'b0;
    cntry    = 2'd0;

    tick(2);
    check("rst_X", 32'(X), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_count", 32'(car_count), 0);
    check("rst_overflow", 32'(overflow), 0);
    clear = 1'b1;
    tick(2);

    // 3-cycle glitch is rejected
    loop_raw = 1'b1;
    tick(3);
    loop_raw = 1'b0;
    tick(12);
    check("glitch_count", 32'(car_count), 0);
    check("glitch_X", 32'(X), 0);

    // Latency: count at edge 7, X at edge 8
    loop_raw = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      check($sformatf("lat_X_e%0d", k), 32'(X), (k == 8) ? 1 : 0);
      check($sformatf("lat_cnt_e%0d", k), 32'(car_count), (k >= 7) ? 1 : 0);
    end
    tick(2);
    loop_raw = 1'b0;
    tick(12);
    check("lat_X_hold", 32'(X), 1);
    check("lat_count_hold", 32'(car_count), 1);

    // First exit empties the queue; X falls one edge later
    exit_raw = 1'b1;
    tick(7);
    check("exit_count0", 32'(car_count), 0);
    check("exit_X_still", 32'(X), 1);
    tick(1);
    check("exit_X_fall", 32'(X), 0);
    tick(2);
    exit_raw = 1'b0;
    tick(12);
    pulse_exit();
    pulse_exit();
    check("nowrap_count", 32'(car_count), 0);
    check("nowrap_X", 32'(X), 0);
    check("nowrap_overflow", 32'(overflow), 0);

    // Saturation and sticky overflow
    repeat (15) pulse_loop();
    check("fill_count", 32'(car_count), 15);
    check("fill_overflow", 32'(overflow), 0);
    pulse_loop();
    check("sat_count", 32'(car_count), 15);
    check("sat_overflow", 32'(overflow), 1);
    repeat (15) pulse_exit();
    check("drain_count", 32'(car_count), 0);
    check("drain_overflow", 32'(overflow), 1);
    check("drain_X", 32'(X), 0);

    // Green timeout and hold-off with two cars queued
    pulse_loop();
    pulse_loop();
    check("q2_count", 32'(car_count), 2);
    check("q2_X", 32'(X), 1);
    cntry = 2'd2;
    tick(31);
    check("green31_X", 32'(X), 1);
    check("green31_timeout", 32'(timeout), 0);
    tick(1);
    check("green32_X", 32'(X), 0);
    check("green32_timeout", 32'(timeout), 1);
    tick(8);
    cntry = 2'd0;
    tick(7);
    check("hold15_X", 32'(X), 0);
    check("hold15_timeout", 32'(timeout), 1);
    tick(1);
    check("hold16_X", 32'(X), 1);
    check("hold16_timeout", 32'(timeout), 0);
    check("hold_count", 32'(car_count), 2);

    // Simultaneous arrival and departure cancel out
    loop_raw = 1'b1;
    exit_raw = 1'b1;
    tick(10);
    check("simul_count_a", 32'(car_count), 2);
    loop_raw = 1'b0;
    exit_raw = 1'b0;
    tick(12);
    check("simul_count_b", 32'(car_count), 2);

    // Asynchronous clear in the middle of hold-off
    cntry = 2'd2;
    tick(32);
    check("pre_clr_timeout", 32'(timeout), 1);
    tick(3);
    #2;
    clear = 1'b0;
    #1;
    check("aclr_X", 32'(X), 0);
    check("aclr_timeout", 32'(timeout), 0);
    check("aclr_count", 32'(car_count), 0);
    check("aclr_overflow", 32'(overflow), 0);
    #2;
    clear = 1'b1;
    cntry = 2'd0;
    tick(2);
    check("post_clr_X", 32'(X), 0);
    check("post_clr_count", 32'(car_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/country_road_sensor.md
COUNTRY_ROAD_SENSOR -- requirements
Module: country_road_sensor

Interface
REQ-001 Parameter DEBOUNCE, default 4: consecutive stable cycles required before a filtered sensor changes.
REQ-002 Parameter CNT_W, default 4: queue counter width; maximum count is 2^CNT_W-1.
REQ-003 Parameter MAX_GREEN, default 32: maximum cycles X stays asserted while cntry==GREEN.
REQ-004 Parameter HOLDOFF, default 16: cycles X is forced low after a MAX_GREEN timeout.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 clear  input  1  reset, asynchronous, active-low.
REQ-007 loop_raw  input  1  unsynchronised arrival loop detector; 1 = vehicle over loop.
REQ-008 exit_raw  input  1  unsynchronised stop-line exit detector; 1 = vehicle over loop.
REQ-009 cntry  input  2  country signal from the controller; RED=0, YELLOW=1, GREEN=2.
REQ-010 X  output  1  car-waiting request to the controller; 1 = cars queued on the country road.
REQ-011 car_count  output  CNT_W  current queue length.
REQ-012 overflow  output  1  sticky flag; an arrival was lost at saturation.
REQ-013 timeout  output  1  high while the FSM is in HOLDOFF_ST.

Function
REQ-014 Each raw input SHALL pass through its own 2-flop synchroniser.
REQ-015 Each synchronised input SHALL feed its own debouncer, with filtered output db and a stability counter. The counter resets whenever the synchronised value equals db. db takes the new value on the edge where the value has differed from db for DEBOUNCE consecutive cycles.
REQ-016 Glitches shorter than DEBOUNCE cycles SHALL NOT change db.
REQ-017 An arrival event SHALL be a 0->1 transition of the arrival db. A departure event SHALL be a 0->1 transition of the exit db. Each event lasts one cycle, registered against the previous db value.
REQ-018 car_count SHALL update on the edge after the event:
- arrival only: +1
- departure only: -1
- both events in the same cycle: unchanged
REQ-019 An arrival at maximum count SHALL leave car_count saturated and set overflow. overflow SHALL stay set until reset.
REQ-020 A departure at car_count==0 SHALL be ignored; car_count SHALL never wrap.
REQ-021 The FSM SHALL have the following states and transitions:
- IDLE_ST (X=0): moves to REQ_ST when car_count!=0.
- REQ_ST (X=1): moves to IDLE_ST when car_count==0. Moves to HOLDOFF_ST when the green timer reaches MAX_GREEN. The car_count==0 exit wins if both occur in the same cycle.
- HOLDOFF_ST (X=0, timeout=1): after HOLDOFF cycles, moves to REQ_ST if car_count!=0, else IDLE_ST.
- Any undefined encoding: moves to IDLE_ST.
REQ-022 The green timer SHALL increment each cycle the FSM is in REQ_ST with cntry==GREEN. It SHALL hold when cntry!=GREEN and clear on every exit from REQ_ST.
REQ-023 The hold-off timer SHALL clear on entry to HOLDOFF_ST.
REQ-024 X and timeout SHALL be decoded from the registered state only, so they are glitch-free.
REQ-025 Latency: for a clean loop_raw rising step, X SHALL rise exactly DEBOUNCE+4 clk edges after the first edge that samples loop_raw high. This is 8 edges with defaults, starting from IDLE_ST with car_count==0.
REQ-026 Changes on cntry SHALL affect only the green timer. They SHALL never alter car_count.

Reset
REQ-027 While clear==0, the block SHALL immediately drive all of the following to 0, independent of clk:
- synchroniser flops, db, debounce counters, event registers
- car_count, overflow, green timer, hold-off timer
- FSM state to IDLE_ST, so X=0 and timeout=0
REQ-028 Reset asserted mid-operation in any state SHALL discard the queue and the timers. The first edge after clear deasserts SHALL evaluate from the reset state.

Verification
REQ-029 Reset then one clean loop_raw pulse of 10 cycles -> car_count=1 and X=1 at edge 8 after the rise; X stays high.
REQ-030 A 3-cycle loop_raw glitch -> car_count stays 0 and X stays 0; 3 clean exit pulses at car_count=1 -> car_count=0 and X falls one edge after the count reaches 0, never wraps.
REQ-031 16 arrivals with CNT_W=4 -> car_count=15 and overflow=1; overflow persists after 15 departures bring car_count to 0.
REQ-032 car_count=2 with cntry held GREEN for 40 cycles -> X falls and timeout=1 after 32 green cycles; X=1 again after 16 hold-off cycles.
REQ-033 Simultaneous debounced arrival and exit edges -> car_count unchanged.
REQ-034 clear pulsed low mid-HOLDOFF_ST, asynchronous to clk -> X=0, timeout=0, car_count=0, overflow=0 immediately.
